// File: rtl/gpu_pkg.sv
// gpu_pkg: dispatch state type, default count width and the block-count helper.
package gpu_pkg;
    localparam int TC_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} disp_state_e;
    // Returns ceil(tc / tpb) for a power-of-two tpb without needing a divider.
    function automatic int block_count(input int tc, input int tpb);
        return (tc + tpb - 1) >> $clog2(tpb);
    endfunction
endpackage

// File: rtl/core_slot_sel.sv
// core_slot_sel: lowest-index set-bit priority encoder.
//   req   : request vector, one bit per slot
//   idx   : index of the lowest set bit (0 when none)
//   valid : at least one bit of req is set
module core_slot_sel #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
        valid = |req;
    end
endmodule

// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel launch into fixed-size blocks and hands them to idle cores.
//   clk, reset          : clock, synchronous active-high reset
//   start, thread_count : level launch request and total thread count
//   core_done           : per-core block-finished flag
//   core_start/core_reset/core_block_id/core_thread_count : per-core block assignment
//   done                : whole kernel retired
module block_dispatcher
    import gpu_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TC_W              = TC_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [TC_W-1:0]           thread_count,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [NUM_CORES-1:0]      core_reset,
    output logic [NUM_CORES*TC_W-1:0] core_block_id,
    output logic [NUM_CORES*TC_W-1:0] core_thread_count,
    output logic                      done
);
    localparam int SW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int LOG_TPB = $clog2(THREADS_PER_BLOCK);
    localparam logic [TC_W:0] TPB = (TC_W + 1)'(THREADS_PER_BLOCK);

    disp_state_e               state_q, state_d;
    logic                      done_q, done_d;
    logic [NUM_CORES-1:0]      core_start_q, core_start_d;
    logic [NUM_CORES-1:0]      core_reset_q, core_reset_d;
    logic [NUM_CORES*TC_W-1:0] block_id_q, block_id_d;
    logic [NUM_CORES*TC_W-1:0] tcount_q, tcount_d;
    logic [TC_W-1:0]           tc_q, tc_d;
    logic [TC_W:0]             dispatched_q, dispatched_d;
    logic [TC_W:0]             bdone_q, bdone_d;
    logic [TC_W:0]             total_q, total_d;
    logic [NUM_CORES-1:0]      comp;
    logic [TC_W:0]             n_comp;
    logic [TC_W:0]             rem;
    logic [SW-1:0]             sel;
    logic                      sel_valid;

    core_slot_sel #(.N(NUM_CORES), .IW(SW)) u_sel (
        .req   (core_reset_q),
        .idx   (sel),
        .valid (sel_valid)
    );

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        core_start_d = core_start_q;
        core_reset_d = core_reset_q;
        block_id_d   = block_id_q;
        tcount_d     = tcount_q;
        tc_d         = tc_q;
        dispatched_d = dispatched_q;
        bdone_d      = bdone_q;
        total_d      = total_q;
        // core_done only counts for cores actually running a block
        comp         = core_start_q & core_done;
        n_comp       = '0;
        for (int i = 0; i < NUM_CORES; i++) n_comp = n_comp + (TC_W + 1)'(comp[i]);
        // threads left from the next block onward; never exceeds tc_q while blocks remain
        rem          = {1'b0, tc_q} - (dispatched_q << LOG_TPB);
        case (state_q)
            IDLE: begin
                core_start_d = '0;
                core_reset_d = '1;
                done_d       = 1'b0;
                if (start) begin
                    tc_d         = thread_count;
                    total_d      = (TC_W + 1)'(block_count(int'(thread_count), THREADS_PER_BLOCK));
                    dispatched_d = '0;
                    bdone_d      = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                core_start_d = core_start_q & ~comp;
                core_reset_d = core_reset_q | comp;
                bdone_d      = bdone_q + n_comp;
                // eligibility uses the registered core_reset, so a core freed this cycle waits one cycle
                if (sel_valid && dispatched_q < total_q) begin
                    core_start_d[sel]              = 1'b1;
                    core_reset_d[sel]              = 1'b0;
                    block_id_d[sel*TC_W +: TC_W]   = dispatched_q[TC_W-1:0];
                    tcount_d[sel*TC_W +: TC_W]     = (rem >= TPB) ? TPB[TC_W-1:0] : rem[TC_W-1:0];
                    dispatched_d                   = dispatched_q + 1'b1;
                end
                if (bdone_d == total_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                core_start_d = '0;
                core_reset_d = '1;
                done_d       = start;
                state_d      = start ? DONE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            core_start_q <= '0;
            core_reset_q <= '1;
            block_id_q   <= '0;
            tcount_q     <= '0;
            tc_q         <= '0;
            dispatched_q <= '0;
            bdone_q      <= '0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            core_start_q <= core_start_d;
            core_reset_q <= core_reset_d;
            block_id_q   <= block_id_d;
            tcount_q     <= tcount_d;
            tc_q         <= tc_d;
            dispatched_q <= dispatched_d;
            bdone_q      <= bdone_d;
            total_q      <= total_d;
        end
    end

    assign core_start        = core_start_q;
    assign core_reset        = core_reset_q;
    assign core_block_id     = block_id_q;
    assign core_thread_count = tcount_q;
    assign done              = done_q;
endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: directed self-checking bench for block_dispatcher.
module tb_block_dispatcher;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  thread_count = '0;
    logic [1:0]  core_done = '0;
    logic [1:0]  core_start;
    logic [1:0]  core_reset;
    logic [15:0] core_block_id;
    logic [15:0] core_thread_count;
    logic        done;
    int          total = 0;
    int          bad = 0;

    block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4), .TC_W(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (core_start !== 2'b00) begin bad++; $display("FAIL rst_start got=%b exp=00", core_start); end
        total++; if (core_reset !== 2'b11) begin bad++; $display("FAIL rst_creset got=%b exp=11", core_reset); end
        total++; if (core_block_id !== 16'h0000) begin bad++; $display("FAIL rst_id got=%h exp=0000", core_block_id); end
        total++; if (core_thread_count !== 16'h0000) begin bad++; $display("FAIL rst_tc got=%h exp=0000", core_thread_count); end
    endtask

    task automatic test_even_kernel();
        start = 1'b1; thread_count = 8'd8;
        tick();
        total++; if (core_start !== 2'b00) begin bad++; $display("FAIL t1_lat0 got=%b exp=00", core_start); end
        tick();
        total++; if (core_start !== 2'b01 || core_reset !== 2'b10) begin bad++; $display("FAIL t1_core0 start=%b reset=%b exp=01/10", core_start, core_reset); end
        total++; if (core_block_id[7:0] !== 8'd0 || core_thread_count[7:0] !== 8'd4) begin bad++; $display("FAIL t1_blk0 id=%0d tc=%0d exp=0/4", core_block_id[7:0], core_thread_count[7:0]); end
        tick();
        total++; if (core_start !== 2'b11) begin bad++; $display("FAIL t1_core1 got=%b exp=11", core_start); end
        total++; if (core_block_id[15:8] !== 8'd1 || core_thread_count[15:8] !== 8'd4) begin bad++; $display("FAIL t1_blk1 id=%0d tc=%0d exp=1/4", core_block_id[15:8], core_thread_count[15:8]); end
        tick();
        total++; if (core_start !== 2'b11) begin bad++; $display("FAIL t1_nomore got=%b exp=11", core_start); end
        core_done = 2'b01;
        tick();
        total++; if (core_start !== 2'b10 || done !== 1'b0) begin bad++; $display("FAIL t1_comp0 start=%b done=%b exp=10/0", core_start, done); end
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        total++; if (done !== 1'b1 || core_start !== 2'b00) begin bad++; $display("FAIL t1_done done=%b start=%b exp=1/00", done, core_start); end
        start = 1'b0;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_idle got=%b exp=0", done); end
    endtask

    task automatic test_partial_block();
        start = 1'b1; thread_count = 8'd10;
        tick(); tick(); tick();
        total++; if (core_start !== 2'b11 || core_thread_count !== 16'h0404) begin bad++; $display("FAIL t2_first start=%b tc=%h exp=11/0404", core_start, core_thread_count); end
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        total++; if (core_start !== 2'b01 || core_reset !== 2'b10) begin bad++; $display("FAIL t2_comp1 start=%b reset=%b exp=01/10", core_start, core_reset); end
        tick();
        total++; if (core_start !== 2'b11 || core_block_id[15:8] !== 8'd2 || core_thread_count[15:8] !== 8'd2) begin bad++; $display("FAIL t2_blk2 start=%b id=%0d tc=%0d exp=11/2/2", core_start, core_block_id[15:8], core_thread_count[15:8]); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t2_early got=%b exp=0", done); end
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t2_done got=%b exp=1", done); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_zero_threads();
        start = 1'b1; thread_count = 8'd0;
        tick();
        total++; if (done !== 1'b0 || core_start !== 2'b00) begin bad++; $display("FAIL t3_run done=%b start=%b exp=0/00", done, core_start); end
        tick();
        total++; if (done !== 1'b1 || core_start !== 2'b00) begin bad++; $display("FAIL t3_done done=%b start=%b exp=1/00", done, core_start); end
        start = 1'b0;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t3_idle got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; thread_count = 8'd16;
        tick(); tick(); tick();
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        total++; if (core_start !== 2'b00 || core_reset !== 2'b11 || done !== 1'b0) begin bad++; $display("FAIL t4_both start=%b reset=%b done=%b exp=00/11/0", core_start, core_reset, done); end
        tick();
        total++; if (core_start !== 2'b01 || core_block_id[7:0] !== 8'd2) begin bad++; $display("FAIL t4_blk2 start=%b id=%0d exp=01/2", core_start, core_block_id[7:0]); end
        tick();
        total++; if (core_start !== 2'b11 || core_block_id[15:8] !== 8'd3 || core_thread_count !== 16'h0404) begin bad++; $display("FAIL t4_blk3 start=%b id=%0d tc=%h exp=11/3/0404", core_start, core_block_id[15:8], core_thread_count); end
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t4_done got=%b exp=1", done); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        start = 1'b1; thread_count = 8'd8;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; thread_count = 8'd4;
        total++; if (core_start !== 2'b00 || core_reset !== 2'b11 || done !== 1'b0) begin bad++; $display("FAIL t5_rst start=%b reset=%b done=%b exp=00/11/0", core_start, core_reset, done); end
        tick(); tick();
        total++; if (core_start !== 2'b01 || core_block_id[7:0] !== 8'd0 || core_thread_count[7:0] !== 8'd4) begin bad++; $display("FAIL t5_fresh start=%b id=%0d tc=%0d exp=01/0/4", core_start, core_block_id[7:0], core_thread_count[7:0]); end
        tick();
        total++; if (core_start !== 2'b01) begin bad++; $display("FAIL t5_single got=%b exp=01", core_start); end
        core_done = 2'b01;
        tick();
        core_done = 2'b00;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t5_done got=%b exp=1", done); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_idle_done_and_hold();
        start = 1'b1; thread_count = 8'd8;
        tick(); tick();
        core_done = 2'b10;
        tick();
        total++; if (core_start !== 2'b11) begin bad++; $display("FAIL t6_ignored got=%b exp=11", core_start); end
        core_done = 2'b01;
        tick();
        total++; if (core_start !== 2'b10 || done !== 1'b0) begin bad++; $display("FAIL t6_one start=%b done=%b exp=10/0", core_start, done); end
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t6_done got=%b exp=1", done); end
        tick(); tick();
        total++; if (done !== 1'b1 || core_reset !== 2'b11) begin bad++; $display("FAIL t6_hold done=%b reset=%b exp=1/11", done, core_reset); end
        start = 1'b0;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t6_drop got=%b exp=0", done); end
        tick();
        total++; if (done !== 1'b0 || core_start !== 2'b00) begin bad++; $display("FAIL t6_idle done=%b start=%b exp=0/00", done, core_start); end
    endtask

    initial begin
        test_reset();
        test_even_kernel();
        test_partial_block();
        test_zero_threads();
        test_back_to_back();
        test_mid_reset();
        test_idle_done_and_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
